// File: rtl/serial_bus_arbiter_rr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : serial_bus_arbiter_rr_pkg                                  |
// | Brief   : Shared state encoding and index-width helpers for the      |
// |           serial-address bus arbiter.                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package serial_bus_arbiter_rr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    CHECK = 3'd2,
    BUSY  = 3'd3
  } bus_state_e;

  function automatic int master_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int slave_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold 0..max_val, never narrower than one bit.
  function automatic int count_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_bus_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : serial_bus_arbiter_rr_pick                                 |
// | Brief   : Combinational round-robin picker: first request at or      |
// |           after the pointer, wrapping.                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module serial_bus_arbiter_rr_pick #(
  parameter int NUM   = 2,
  parameter int IDX_W = 1
) (
  input  logic [NUM-1:0]   i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NUM-1:0]   o_grant,
  output logic [IDX_W-1:0] o_index,
  output logic             o_found
);

  logic [NUM-1:0] w_rot;
  logic [IDX_W:0] w_sum;

  always_comb begin
    // Rotating a doubled copy puts the pointer position at bit 0.
    w_rot   = NUM'({i_req, i_req} >> i_ptr);
    o_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < NUM; i++) begin
      if (!o_found && w_rot[i]) begin
        o_found = 1'b1;
        w_sum   = {1'b0, i_ptr} + (IDX_W+1)'(i);
      end
    end
    if (w_sum >= (IDX_W+1)'(NUM)) begin
      w_sum = w_sum - (IDX_W+1)'(NUM);
    end
    o_index = w_sum[IDX_W-1:0];
    o_grant = '0;
    for (int j = 0; j < NUM; j++) begin
      o_grant[j] = o_found && (o_index == IDX_W'(j));
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_bus_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : serial_bus_arbiter_rr                                      |
// | Brief   : Round-robin arbiter/router for the serial-address bus with |
// |           decode-error and idle-timeout release.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module serial_bus_arbiter_rr
  import serial_bus_arbiter_rr_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int ADDR_W      = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_request,
  input  logic [NUM_MASTERS-1:0] m_address_valid,
  input  logic [NUM_MASTERS-1:0] m_address,
  input  logic [NUM_MASTERS-1:0] m_data,
  input  logic [NUM_MASTERS-1:0] m_valid,
  output logic [NUM_MASTERS-1:0] m_data_out,
  output logic [NUM_MASTERS-1:0] m_ready,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [NUM_MASTERS-1:0] m_error,
  output logic [NUM_SLAVES-1:0]  s_address,
  output logic [NUM_SLAVES-1:0]  s_data,
  output logic [NUM_SLAVES-1:0]  s_valid,
  input  logic [NUM_SLAVES-1:0]  s_data_in,
  input  logic [NUM_SLAVES-1:0]  s_ready,
  output logic [2:0]             state
);

  localparam int c_m_w   = master_idx_w(NUM_MASTERS);
  localparam int c_bit_w = count_w(ADDR_W - 1);
  localparam int c_to_w  = count_w(TIMEOUT_CYC);

  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(ADDR_W - 1);
  localparam logic [c_to_w-1:0]  c_to_max   = c_to_w'(TIMEOUT_CYC);
  localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [ADDR_W:0]    c_ns       = (ADDR_W+1)'(NUM_SLAVES);

  bus_state_e             r_state;
  logic [c_m_w-1:0]       r_owner;
  logic [c_m_w-1:0]       r_ptr;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] r_error;
  logic [NUM_SLAVES-1:0]  r_route;
  logic [ADDR_W-1:0]      r_addr_buf;
  logic [c_bit_w-1:0]     r_bit_cnt;
  logic [c_to_w-1:0]      r_to_cnt;

  logic [NUM_MASTERS-1:0] w_pick_grant;
  logic [c_m_w-1:0]       w_pick_idx;
  logic                   w_pick_found;
  logic [NUM_SLAVES-1:0]  w_route_dec;
  logic [ADDR_W-1:0]      w_addr_shift;
  logic [c_m_w-1:0]       w_ptr_next;
  logic                   w_own_req;
  logic                   w_own_addr_valid;
  logic                   w_own_addr_bit;
  logic                   w_own_valid;
  logic                   w_own_data;
  logic                   w_shift_in_range;
  logic                   w_buf_in_range;
  logic                   w_timeout;

  serial_bus_arbiter_rr_pick #(
    .NUM   (NUM_MASTERS),
    .IDX_W (c_m_w)
  ) u_pick (
    .i_req   (m_request & m_address_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_index (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_own_req        = |(r_grant & m_request);
  assign w_own_addr_valid = |(r_grant & m_address_valid);
  assign w_own_addr_bit   = |(r_grant & m_address);
  assign w_own_valid      = |(r_grant & m_valid);
  assign w_own_data       = |(r_grant & m_data);
  assign w_addr_shift     = ADDR_W'({r_addr_buf, w_own_addr_bit});
  assign w_shift_in_range = ({1'b0, w_addr_shift} < c_ns);
  assign w_buf_in_range   = ({1'b0, r_addr_buf} < c_ns);
  assign w_ptr_next       = (r_owner == c_m_w'(NUM_MASTERS - 1)) ? '0 : r_owner + c_m_w'(1);
  assign w_timeout        = (TIMEOUT_CYC != 0) && !w_own_valid && (r_to_cnt == c_to_last);

  always_comb begin
    w_route_dec = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      w_route_dec[s] = (r_addr_buf == ADDR_W'(s));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_error    <= '0;
      r_route    <= '0;
      r_addr_buf <= '0;
      r_bit_cnt  <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_error <= '0;
      case (r_state)
        IDLE: begin
          if (w_pick_found) begin
            r_owner    <= w_pick_idx;
            r_grant    <= w_pick_grant;
            r_addr_buf <= '0;
            r_bit_cnt  <= '0;
            r_state    <= ADDR;
          end
        end
        ADDR: begin
          if (!w_own_req) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_route <= '0;
            r_ptr   <= w_ptr_next;
          end else begin
            r_addr_buf <= w_addr_shift;
            if (r_bit_cnt == c_bit_last) begin
              // Flag the decode error on entry so the pulse lands in CHECK.
              r_state <= CHECK;
              if (!w_shift_in_range) begin
                r_error <= r_grant;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
            end
          end
        end
        CHECK: begin
          if (w_buf_in_range) begin
            r_route  <= w_route_dec;
            r_to_cnt <= '0;
            r_state  <= BUSY;
          end else begin
            r_state <= IDLE;
            r_grant <= '0;
            r_route <= '0;
            r_ptr   <= w_ptr_next;
          end
        end
        BUSY: begin
          if (!w_own_req) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_route  <= '0;
            r_to_cnt <= '0;
            r_ptr    <= w_ptr_next;
          end else if (w_own_addr_valid) begin
            r_route    <= '0;
            r_addr_buf <= '0;
            r_bit_cnt  <= '0;
            r_to_cnt   <= '0;
            r_state    <= ADDR;
          end else if (w_timeout) begin
            r_error  <= r_grant;
            r_state  <= IDLE;
            r_grant  <= '0;
            r_route  <= '0;
            r_to_cnt <= '0;
            r_ptr    <= w_ptr_next;
          end else if (w_own_valid) begin
            r_to_cnt <= '0;
          end else if (r_to_cnt != c_to_max) begin
            r_to_cnt <= r_to_cnt + c_to_w'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_route <= '0;
        end
      endcase
    end
  end

  // Route bits are only ever set while BUSY, so they gate all forwarding.
  for (genvar gm = 0; gm < NUM_MASTERS; gm++) begin : g_master
    assign m_data_out[gm] = r_grant[gm] & |(r_route & s_data_in);
    assign m_ready[gm]    = r_grant[gm] & |(r_route & s_ready);
  end

  for (genvar gs = 0; gs < NUM_SLAVES; gs++) begin : g_slave
    assign s_address[gs] = r_route[gs] & w_own_addr_bit;
    assign s_data[gs]    = r_route[gs] & w_own_data;
    assign s_valid[gs]   = r_route[gs] & w_own_valid & (r_state == BUSY);
  end

  assign m_grant = r_grant;
  assign m_error = r_error;
  assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_serial_bus_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_serial_bus_arbiter_rr                                   |
// | Brief   : Directed and randomized bench for serial_bus_arbiter_rr.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_serial_bus_arbiter_rr;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam int AW = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NM-1:0] m_request, m_address_valid, m_address, m_data, m_valid;
  logic [NM-1:0] m_data_out, m_ready, m_grant, m_error;
  logic [NS-1:0] s_address, s_data, s_valid, s_data_in, s_ready;
  logic [2:0]    state;

  int n_checks  = 0;
  int n_pass    = 0;
  int ptr_model = 0;

  always #5 clk = ~clk;

  serial_bus_arbiter_rr #(
    .NUM_MASTERS (NM),
    .NUM_SLAVES  (NS),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .m_request       (m_request),
    .m_address_valid (m_address_valid),
    .m_address       (m_address),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_data_out      (m_data_out),
    .m_ready         (m_ready),
    .m_grant         (m_grant),
    .m_error         (m_error),
    .s_address       (s_address),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_data_in       (s_data_in),
    .s_ready         (s_ready),
    .state           (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    m_request = '0; m_address_valid = '0; m_address = '0;
    m_data = '0; m_valid = '0; s_data_in = '0; s_ready = '0;
  endtask

  // First requesting master at or after the pointer, wrapping.
  function automatic int rr_expect(input int mask, input int ptr);
    for (int i = 0; i < NM; i++) begin
      if (((mask >> ((ptr + i) % NM)) & 1) == 1) return (ptr + i) % NM;
    end
    return -1;
  endfunction

  task automatic reset_check(input string tag);
    reset = 1'b1;
    m_valid = '1;
    step();
    #1;
    chk({tag, "_state"}, state, 0);
    chk({tag, "_grant"}, m_grant, 0);
    chk({tag, "_error"}, m_error, 0);
    chk({tag, "_s_valid"}, s_valid, 0);
    reset = 1'b0;
    clear_inputs();
    ptr_model = 0;
  endtask

  task automatic start(input int mask, input int exp_owner);
    m_request = NM'(mask);
    m_address_valid = NM'(mask);
    step();
    m_address_valid = '0;
    chk("grant_t1", m_grant, 1 << exp_owner);
    chk("addr_state", state, 1);
  endtask

  task automatic send_addr(input int o, input int addr);
    m_valid = '1;
    for (int b = AW - 1; b >= 0; b--) begin
      m_address = NM'(((addr >> b) & 1) << o);
      step();
    end
    #1;
    chk("check_state", state, 2);
    chk("check_grant", m_grant, 1 << o);
    chk("check_error", m_error, (addr >= NS) ? (1 << o) : 0);
    chk("check_s_valid", s_valid, 0);
    step();
    if (addr < NS) begin
      chk("busy_state", state, 3);
    end else begin
      chk("err_idle_state", state, 0);
      chk("err_pulse_end", m_error, 0);
      chk("err_grant_drop", m_grant, 0);
      ptr_model = (o + 1) % NM;
    end
    m_valid = '0;
  endtask

  task automatic busy_cycle(input int o, input int s);
    int mv, md, ma, sdi, srd;
    m_request       = NM'($urandom) | NM'(1 << o);
    m_address_valid = NM'($urandom) & ~NM'(1 << o);
    m_address = NM'($urandom); m_data = NM'($urandom); m_valid = NM'($urandom);
    s_data_in = NS'($urandom); s_ready = NS'($urandom);
    #1;
    mv = int'(m_valid); md = int'(m_data); ma = int'(m_address);
    sdi = int'(s_data_in); srd = int'(s_ready);
    chk("busy_state", state, 3);
    chk("busy_grant", m_grant, 1 << o);
    chk("s_valid", s_valid, ((mv >> o) & 1) << s);
    chk("s_data", s_data, ((md >> o) & 1) << s);
    chk("s_address", s_address, ((ma >> o) & 1) << s);
    chk("m_data_out", m_data_out, ((sdi >> s) & 1) << o);
    chk("m_ready", m_ready, ((srd >> s) & 1) << o);
    step();
  endtask

  task automatic release_bus(input int o);
    m_request = '0;
    m_address_valid = '0;
    step();
    chk("rel_state", state, 0);
    chk("rel_grant", m_grant, 0);
    ptr_model = (o + 1) % NM;
  endtask

  initial begin
    int mask, o, a, n;
    clear_inputs();
    reset = 1'b1;
    step();
    reset_check("reset");

    // Single master, address 2'b10 -> slave 2.
    start(1, 0);
    send_addr(0, 2);
    m_valid = 2'b01;
    #1 chk("s2_follow_hi", s_valid, 3'b100);
    m_valid = 2'b00;
    #1 chk("s2_follow_lo", s_valid, 3'b000);
    busy_cycle(0, 2);
    busy_cycle(0, 2);
    release_bus(0);

    // Simultaneous requests resolved by the pointer.
    reset_check("reset2");
    start(3, 0);
    send_addr(0, 0);
    busy_cycle(0, 0);
    release_bus(0);
    start(3, 1);
    send_addr(1, 1);
    release_bus(1);

    // Out-of-range address.
    start(1, 0);
    send_addr(0, 3);
    chk("err_ptr_next", rr_expect(3, ptr_model), 1);

    // Timeout with m_valid held low.
    start(2, 1);
    send_addr(1, 0);
    for (int i = 0; i < TO; i++) begin
      #1 chk("to_busy_hold", state, 3);
      step();
    end
    chk("to_idle", state, 0);
    chk("to_error", m_error, 2'b10);
    chk("to_grant", m_grant, 0);
    step();
    chk("to_error_end", m_error, 0);
    m_request = '0;
    ptr_model = 0;

    // m_valid toggling every 3 cycles never times out.
    start(1, 0);
    send_addr(0, 1);
    for (int c = 0; c < 18; c++) begin
      m_valid = NM'((c / 3) % 2);
      #1 chk("toggle_busy", state, 3);
      step();
    end
    release_bus(0);

    // Re-address from slave 0 to slave 1 while keeping ownership.
    start(3, 1);
    send_addr(1, 0);
    busy_cycle(1, 0);
    m_request = 2'b10;
    m_address_valid = 2'b10;
    m_valid = '1;
    step();
    m_address_valid = '0;
    #1;
    chk("readdr_state", state, 1);
    chk("readdr_grant", m_grant, 2'b10);
    chk("readdr_route", s_valid, 0);
    send_addr(1, 1);
    busy_cycle(1, 1);
    release_bus(1);

    // Reset in ADDR and in BUSY returns the pointer to master 0.
    start(1, 0);
    send_addr(0, 0);
    release_bus(0);
    start(3, 1);
    reset_check("rst_addr");
    start(3, 0);
    send_addr(0, 1);
    release_bus(0);
    start(3, 1);
    send_addr(1, 2);
    busy_cycle(1, 2);
    reset_check("rst_busy");
    start(3, 0);
    send_addr(0, 0);
    release_bus(0);

    // Randomized transactions against the pointer model.
    for (int t = 0; t < 30; t++) begin
      mask = $urandom_range(1, 3);
      o = rr_expect(mask, ptr_model);
      a = $urandom_range(0, 3);
      start(mask, o);
      send_addr(o, a);
      if (a < NS) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) busy_cycle(o, a);
        release_bus(o);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
